// File: rtl/mips_pkg.sv
// Shared definitions for the memory bus bridge: FSM encoding, widths,
// timeout default and the load/store opcode classes.
package mips_pkg;

    localparam int unsigned ADDR_W             = 32;
    localparam int unsigned DATA_W             = 32;
    localparam int unsigned CNT_W              = 8;
    localparam int unsigned TIMEOUT_CYCLES_DEF = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_DONE = 2'd2,
        ST_ERR  = 2'd3
    } state_e;

    // Opcode classes that raise MemRead / MemWrite in the controller
    localparam logic [5:0] OP_LW = 6'h23;
    localparam logic [5:0] OP_SW = 6'h2b;

    typedef struct packed {
        logic mem_read;
        logic mem_write;
    } mem_ctl_t;

    function automatic mem_ctl_t mem_ctl_for_op(input logic [5:0] op);
        mem_ctl_t ctl;
        ctl = '0;
        case (op)
            OP_LW:   ctl.mem_read  = 1'b1;
            OP_SW:   ctl.mem_write = 1'b1;
            default: ctl = '0;
        endcase
        return ctl;
    endfunction

endpackage

// File: rtl/mem_bus_bridge_if.sv
// Controller-side request/response and memory-side bus signals of the bridge.
interface mem_bus_bridge_if;
    import mips_pkg::*;

    logic              MemRead;
    logic              MemWrite;
    logic [ADDR_W-1:0] Address;
    logic [DATA_W-1:0] WriteData;
    logic [DATA_W-1:0] bus_rdata;
    logic              bus_ack;

    logic              bus_req;
    logic              bus_we;
    logic [ADDR_W-1:0] bus_addr;
    logic [DATA_W-1:0] bus_wdata;
    logic [DATA_W-1:0] ReadData;
    logic              Stall;
    logic              Done;
    logic              AddrErr;
    logic              Timeout;

    // The bridge itself
    modport slave (
        input  MemRead, MemWrite, Address, WriteData, bus_rdata, bus_ack,
        output bus_req, bus_we, bus_addr, bus_wdata, ReadData, Stall, Done,
               AddrErr, Timeout
    );

    // Controller plus memory environment around the bridge
    modport master (
        output MemRead, MemWrite, Address, WriteData, bus_rdata, bus_ack,
        input  bus_req, bus_we, bus_addr, bus_wdata, ReadData, Stall, Done,
               AddrErr, Timeout
    );

endinterface

// File: rtl/mem_bus_bridge_wait_timer.sv
// REQ-state wait counter: clears while outside REQ, counts un-acked cycles,
// flags the terminal count.
module wait_timer #(
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned TERMINAL = 15
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic tc_c
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (en) begin
            count_d = count_q + WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign tc_c = (count_q == WIDTH'(TERMINAL));

endmodule

// File: rtl/mem_bus_bridge.sv
// Multicycle-CPU memory bridge: turns MemRead/MemWrite into a req/ack bus
// cycle with alignment check, bounded wait and a one-cycle completion pulse.
module mem_bus_bridge
    import mips_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
    input  logic             clk,
    input  logic             reset,
    mem_bus_bridge_if.slave  bus
);

    state_e            state_q, state_d;
    logic              bus_req_q, bus_req_d;
    logic              bus_we_q, bus_we_d;
    logic [ADDR_W-1:0] bus_addr_q, bus_addr_d;
    logic [DATA_W-1:0] bus_wdata_q, bus_wdata_d;
    logic [DATA_W-1:0] read_data_q, read_data_d;
    logic              done_q, done_d;
    logic              addr_err_q, addr_err_d;
    logic              timeout_q, timeout_d;

    logic              req_c;
    logic              aligned_c;
    logic              tc_c;
    logic              tmr_clr_c;
    logic              tmr_en_c;

    assign req_c     = bus.MemRead | bus.MemWrite;
    assign aligned_c = (bus.Address[1:0] == 2'b00);
    assign tmr_clr_c = (state_q != ST_REQ);
    assign tmr_en_c  = (state_q == ST_REQ) & ~bus.bus_ack;

    wait_timer #(
        .WIDTH    (CNT_W),
        .TERMINAL (TIMEOUT_CYCLES - 1)
    ) u_wait_timer (
        .clk   (clk),
        .reset (reset),
        .clr   (tmr_clr_c),
        .en    (tmr_en_c),
        .tc_c  (tc_c)
    );

    // Next-state and registered-output logic
    always_comb begin
        state_d     = state_q;
        bus_we_d    = bus_we_q;
        bus_addr_d  = bus_addr_q;
        bus_wdata_d = bus_wdata_q;
        read_data_d = read_data_q;
        addr_err_d  = 1'b0;
        timeout_d   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (req_c) begin
                    if (aligned_c) begin
                        state_d     = ST_REQ;
                        bus_we_d    = bus.MemWrite;
                        bus_addr_d  = {bus.Address[ADDR_W-1:2], 2'b00};
                        bus_wdata_d = bus.WriteData;
                    end else begin
                        state_d    = ST_ERR;
                        addr_err_d = 1'b1;
                    end
                end
            end
            ST_REQ: begin
                // Ack on the terminal cycle still completes the access
                if (bus.bus_ack) begin
                    state_d = ST_DONE;
                    if (!bus_we_q) begin
                        read_data_d = bus.bus_rdata;
                    end
                end else if (tc_c) begin
                    state_d   = ST_ERR;
                    timeout_d = 1'b1;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            ST_ERR:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        bus_req_d = (state_d == ST_REQ);
        done_d    = (state_d == ST_DONE) | (state_d == ST_ERR);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            bus_req_q   <= 1'b0;
            bus_we_q    <= 1'b0;
            bus_addr_q  <= '0;
            bus_wdata_q <= '0;
            read_data_q <= '0;
            done_q      <= 1'b0;
            addr_err_q  <= 1'b0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            bus_req_q   <= bus_req_d;
            bus_we_q    <= bus_we_d;
            bus_addr_q  <= bus_addr_d;
            bus_wdata_q <= bus_wdata_d;
            read_data_q <= read_data_d;
            done_q      <= done_d;
            addr_err_q  <= addr_err_d;
            timeout_q   <= timeout_d;
        end
    end

    // Stall must react in the request cycle itself, so it is combinational
    assign bus.Stall     = ~reset & ((state_q == ST_REQ) |
                                     ((state_q == ST_IDLE) & req_c & aligned_c));
    assign bus.bus_req   = bus_req_q;
    assign bus.bus_we    = bus_we_q;
    assign bus.bus_addr  = bus_addr_q;
    assign bus.bus_wdata = bus_wdata_q;
    assign bus.ReadData  = read_data_q;
    assign bus.Done      = done_q;
    assign bus.AddrErr   = addr_err_q;
    assign bus.Timeout   = timeout_q;

endmodule

// File: tb/tb_mem_bus_bridge.sv
// Directed scoreboard bench for mem_bus_bridge: stimulus pushes the expected
// completion, a negedge monitor pops and compares on every Done pulse.
module tb_mem_bus_bridge;
    import mips_pkg::*;

    localparam int unsigned TMO = 16;

    typedef struct packed {
        logic        addr_err;
        logic        timeout;
        logic [31:0] rdata;
    } exp_t;

    logic clk;
    logic reset;
    mem_bus_bridge_if bus ();

    mem_bus_bridge #(.TIMEOUT_CYCLES(TMO)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int   n_checks = 0;
    int   n_fail   = 0;
    exp_t sb_q[$];
    logic [31:0] exp_rd;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Scoreboard monitor: every Done pulse must match the oldest expectation
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (bus.Done === 1'b1) begin
                if (sb_q.size() == 0) begin
                    check("unexpected_done", 32'd1, 32'd0);
                end else begin
                    e = sb_q.pop_front();
                    check("sb_addr_err", 32'(bus.AddrErr), 32'(e.addr_err));
                    check("sb_timeout",  32'(bus.Timeout), 32'(e.timeout));
                    check("sb_read_data", bus.ReadData, e.rdata);
                end
            end
        end
    end

    // One controller access; wait_n = un-acked REQ cycles before ack
    task automatic access(input string tag, input logic rd, input logic wr,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [31:0] rdata, input int wait_n, input bit ack_en);
        bit   aligned;
        int   n;
        int   exp_n;
        exp_t e;
        aligned = (addr[1:0] == 2'b00);
        exp_n   = !aligned ? 0 : (ack_en ? wait_n + 1 : int'(TMO));
        e.addr_err = !aligned;
        e.timeout  = aligned && !ack_en;
        if (aligned && ack_en && !wr) exp_rd = rdata;
        e.rdata = exp_rd;
        sb_q.push_back(e);

        @(posedge clk); #1;
        bus.MemRead   = rd;
        bus.MemWrite  = wr;
        bus.Address   = addr;
        bus.WriteData = wdata;
        @(negedge clk);
        check({tag, "_stall_c0"}, 32'(bus.Stall), 32'(aligned));
        @(posedge clk); #1;
        bus.MemRead   = 1'b0;
        bus.MemWrite  = 1'b0;
        bus.Address   = 32'hFFFF_FFFF;
        bus.WriteData = 32'h5555_AAAA;

        n = 0;
        for (int c = 0; c < 64; c++) begin
            @(negedge clk);
            if (bus.bus_req !== 1'b1) break;
            n++;
            check({tag, "_req_stall"}, 32'(bus.Stall), 32'd1);
            check({tag, "_req_we"},    32'(bus.bus_we), 32'(wr));
            check({tag, "_req_addr"},  bus.bus_addr, addr);
            check({tag, "_req_wdata"}, bus.bus_wdata, wdata);
            if (ack_en && (n - 1 == wait_n)) begin
                bus.bus_ack   = 1'b1;
                bus.bus_rdata = rdata;
            end else begin
                bus.bus_ack   = 1'b0;
                bus.bus_rdata = 32'hBAD0_BAD0;
            end
        end
        bus.bus_ack = 1'b0;
        check({tag, "_req_cycles"}, 32'(n), 32'(exp_n));
        check({tag, "_done_pulse"}, 32'(bus.Done), 32'd1);
        check({tag, "_stall_end"},  32'(bus.Stall), 32'd0);
        @(negedge clk);
        check({tag, "_done_clear"}, 32'(bus.Done), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        mem_ctl_t ctl;
        exp_rd        = 32'h0;
        reset         = 1'b1;
        bus.MemRead   = 1'b1;
        bus.MemWrite  = 1'b0;
        bus.Address   = 32'h0000_0010;
        bus.WriteData = 32'h0;
        bus.bus_rdata = 32'h0;
        bus.bus_ack   = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_bus_req",   32'(bus.bus_req), 32'd0);
        check("rst_bus_we",    32'(bus.bus_we),  32'd0);
        check("rst_bus_addr",  bus.bus_addr,     32'd0);
        check("rst_bus_wdata", bus.bus_wdata,    32'd0);
        check("rst_read_data", bus.ReadData,     32'd0);
        check("rst_done",      32'(bus.Done),    32'd0);
        check("rst_addr_err",  32'(bus.AddrErr), 32'd0);
        check("rst_timeout",   32'(bus.Timeout), 32'd0);
        check("rst_stall",     32'(bus.Stall),   32'd0);
        @(posedge clk); #1;
        reset       = 1'b0;
        bus.MemRead = 1'b0;

        ctl = mem_ctl_for_op(OP_LW);
        access("lw0", ctl.mem_read, ctl.mem_write, 32'h0000_0010, 32'h0, 32'h1234_5678, 0, 1'b1);
        ctl = mem_ctl_for_op(OP_SW);
        access("sw3", ctl.mem_read, ctl.mem_write, 32'h0000_0020, 32'hCAFE_F00D, 32'hEEEE_EEEE, 3, 1'b1);
        access("lw_mis", 1'b1, 1'b0, 32'h0000_0013, 32'h0, 32'h0, 0, 1'b1);
        access("lw_tmo", 1'b1, 1'b0, 32'h0000_0040, 32'h0, 32'h0, 0, 1'b0);
        access("lw_last", 1'b1, 1'b0, 32'h0000_0044, 32'h0, 32'hA5A5_0001, int'(TMO) - 1, 1'b1);
        access("rw_both", 1'b1, 1'b1, 32'h0000_0048, 32'h0BAD_BEEF, 32'hFFFF_0000, 1, 1'b1);
        access("sw_mis", 1'b0, 1'b1, 32'h0000_004A, 32'h1111_2222, 32'h0, 0, 1'b1);

        // Reset in the second REQ cycle discards the access
        @(posedge clk); #1;
        bus.MemRead = 1'b1;
        bus.Address = 32'h0000_0060;
        @(posedge clk); #1;
        bus.MemRead = 1'b0;
        @(negedge clk);
        check("rstmid_req_c1", 32'(bus.bus_req), 32'd1);
        @(posedge clk); #1;
        reset = 1'b1;
        @(negedge clk);
        check("rstmid_stall", 32'(bus.Stall), 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        check("rstmid_bus_req",   32'(bus.bus_req), 32'd0);
        check("rstmid_done",      32'(bus.Done),    32'd0);
        check("rstmid_bus_addr",  bus.bus_addr,     32'd0);
        check("rstmid_read_data", bus.ReadData,     32'd0);
        exp_rd = 32'h0;

        // Stray ack while idle must change nothing
        bus.bus_ack   = 1'b1;
        bus.bus_rdata = 32'hDEAD_BEEF;
        repeat (3) begin
            @(negedge clk);
            check("stray_bus_req",   32'(bus.bus_req), 32'd0);
            check("stray_read_data", bus.ReadData,     32'd0);
            check("stray_done",      32'(bus.Done),    32'd0);
        end
        bus.bus_ack = 1'b0;

        access("lw_after", 1'b1, 1'b0, 32'h0000_0050, 32'h0, 32'h0F0F_F0F0, 2, 1'b1);

        repeat (2) @(negedge clk);
        check("sb_drained", 32'(sb_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_bus_bridge.md
MEM_BUS_BRIDGE -- requirements
Module: mem_bus_bridge

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 16, SHALL be the maximum REQ-state cycles to wait for bus_ack before aborting (legal range 2..255).
REQ-002 clk  input  1  SHALL be the single clock; all state changes on its rising edge.
REQ-003 reset  input  1  SHALL be a synchronous, active-high reset sampled on the rising edge of clk.
REQ-004 MemRead  input  1  SHALL be the controller's read-access request.
REQ-005 MemWrite  input  1  SHALL be the controller's write-access request.
REQ-006 Address  input  32  SHALL be the byte address of the access (IorD-muxed by the datapath).
REQ-007 WriteData  input  32  SHALL be the store data.
REQ-008 bus_rdata  input  32  SHALL be the memory-side read data, valid when bus_ack=1.
REQ-009 bus_ack  input  1  SHALL be the memory-side completion strobe.
REQ-010 bus_req  output  1  SHALL be the memory-side request, held until ack or timeout.
REQ-011 bus_we  output  1  SHALL be the memory-side write enable (1=write), valid while bus_req=1.
REQ-012 bus_addr  output  32  SHALL be the latched word-aligned address.
REQ-013 bus_wdata  output  32  SHALL be the latched store data.
REQ-014 ReadData  output  32  SHALL be the registered load result (feeds the MDR/MemtoReg path).
REQ-015 Stall  output  1  SHALL tell the controller to hold its state.
REQ-016 Done  output  1  SHALL be a one-cycle completion pulse (success or error).
REQ-017 AddrErr  output  1  SHALL be a one-cycle misalignment-error pulse.
REQ-018 Timeout  output  1  SHALL be a one-cycle bus-timeout pulse.

Function
REQ-019 The FSM SHALL have states IDLE, REQ, DONE, ERR; only IDLE accepts new requests.
REQ-020 In IDLE, a request (MemRead|MemWrite) SHALL be sampled; if Address[1:0]!=0, next state ERR and AddrErr pulses in ERR; no bus cycle is issued.
REQ-021 In IDLE with an aligned request, Address, WriteData and bus_we=MemWrite SHALL be latched and the next state SHALL be REQ.
REQ-022 If MemRead and MemWrite are both 1, write SHALL take priority (bus_we=1, ReadData unchanged).
REQ-023 bus_req SHALL be 1 exactly while state=REQ; bus_addr/bus_we/bus_wdata SHALL be stable for that whole interval.
REQ-024 In REQ, bus_ack=1 SHALL move to DONE; on a read, bus_rdata SHALL be captured into ReadData on that same edge.
REQ-025 A wait counter SHALL clear on REQ entry, increment each REQ cycle without ack; on reaching TIMEOUT_CYCLES-1 without ack the FSM SHALL go to ERR with Timeout pulsing in ERR; ack on the final cycle SHALL win over timeout.
REQ-026 DONE and ERR SHALL last exactly one cycle, assert Done=1, then return to IDLE; requests present in DONE/ERR SHALL be ignored.
REQ-027 Stall SHALL equal (state==REQ) | (state==IDLE & (MemRead|MemWrite) & Address[1:0]==0); Stall SHALL be 0 in DONE and ERR.
REQ-028 Zero-wait latency: request in cycle 0, bus_req in cycle 1, ack in cycle 1, Done/ReadData valid in cycle 2; Stall high in cycles 0-1.
REQ-029 bus_ack outside REQ SHALL be ignored, with no state or ReadData change.
REQ-030 ReadData SHALL hold its value until the next successful read; errors SHALL NOT modify it.

Reset
REQ-031 On reset: state=IDLE, counter=0, bus_req=0, bus_we=0, bus_addr=0, bus_wdata=0, ReadData=0, Done=0, AddrErr=0, Timeout=0; Stall SHALL be 0 during reset cycles.
REQ-032 Reset asserted mid-transaction (REQ) SHALL drop bus_req on the next edge and discard the access with no Done pulse.

Structure
REQ-033 State encoding, TIMEOUT_CYCLES default and the MemRead/MemWrite opcode-class constants SHALL live in shared package mips_pkg.
REQ-034 The wait counter SHALL be a sub-module wait_timer (clear, enable, terminal-count output); the rest stays flat.

Verification
REQ-035 Zero-wait lw: Address=0x0000_0010, ack in first REQ cycle, bus_rdata=0x1234_5678 -> Done cycle 2, ReadData=0x1234_5678, Stall high cycles 0-1.
REQ-036 sw with 3 wait cycles: Address=0x20, WriteData=0xCAFE_F00D -> bus_req high 4 cycles, bus_we=1, bus_wdata stable, Done one cycle after ack, ReadData unchanged.
REQ-037 Misaligned lw Address=0x0000_0013 -> bus_req never asserts, AddrErr and Done pulse one cycle later, Stall never high.
REQ-038 No ack, TIMEOUT_CYCLES=16 -> bus_req high exactly 16 cycles, then Timeout+Done pulse, ReadData unchanged.
REQ-039 Reset asserted in 2nd REQ cycle -> bus_req low next cycle, no Done, all outputs at reset values; stray ack in IDLE -> no effect.
